// File: rtl/jtag_gpios_pkg.sv
// Shared register-select and update-operation codes for the JTAG GPIO block.
package jtag_gpios_pkg;

  localparam int SEL_W = 2;
  localparam int OP_W  = 2;

  localparam logic [SEL_W-1:0] SEL_OE   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_OUT  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_IN   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_EDGE = 2'd3;

  localparam logic [OP_W-1:0] OP_NOP   = 2'd0;
  localparam logic [OP_W-1:0] OP_WRITE = 2'd1;
  localparam logic [OP_W-1:0] OP_SET   = 2'd2;
  localparam logic [OP_W-1:0] OP_CLR   = 2'd3;

endpackage

// File: rtl/jtag_gpio_edge_detect.sv
// Input synchroniser into tck plus sticky per-pin change flags.
// A change and a clear hitting the same bit in one cycle leaves the flag set.
module jtag_gpio_edge_detect #(
  parameter int NR_GPIOS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                tck,
  input  logic                reset_,
  input  logic [NR_GPIOS-1:0] gpio_inputs,
  input  logic [NR_GPIOS-1:0] clr_mask,
  output logic [NR_GPIOS-1:0] in_sync,
  output logic [NR_GPIOS-1:0] edge_flags
);

  logic [SYNC_STAGES-1:0][NR_GPIOS-1:0] r_sync;
  logic [NR_GPIOS-1:0]                  r_prev;
  logic [NR_GPIOS-1:0]                  r_flags;
  logic [NR_GPIOS-1:0]                  w_edge;

  assign in_sync    = r_sync[SYNC_STAGES-1];
  assign w_edge     = in_sync ^ r_prev;
  assign edge_flags = r_flags;

  always_ff @(posedge tck) begin
    if (!reset_) begin
      r_sync  <= '0;
      r_prev  <= '0;
      r_flags <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], gpio_inputs};
      r_prev  <= in_sync;
      // set is OR'ed in after the clear so a simultaneous edge survives
      r_flags <= (r_flags & ~clr_mask) | w_edge;
    end
  end

endmodule

// File: rtl/jtag_gpios_ext.sv
// JTAG-scanned GPIO group: SCAN_N picks one of four registers, EXTEST reads it
// and applies a write/set/clear op carried in the top two bits of the scan.
module jtag_gpios_ext
  import jtag_gpios_pkg::*;
#(
  parameter int NR_GPIOS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                tck,
  input  logic                reset_,
  input  logic                tdi,
  output logic                gpios_tdo,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                scan_n_ir,
  input  logic                extest_ir,
  input  logic [NR_GPIOS-1:0] gpio_inputs,
  output logic [NR_GPIOS-1:0] gpio_outputs,
  output logic [NR_GPIOS-1:0] gpio_outputs_ena,
  output logic                gpio_edge_pending
);

  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_sel_sr;
  logic [NR_GPIOS+1:0] r_dr;
  logic [NR_GPIOS-1:0] r_oe;
  logic [NR_GPIOS-1:0] r_out;

  logic [NR_GPIOS-1:0] w_in_sync;
  logic [NR_GPIOS-1:0] w_edge_flags;
  logic [NR_GPIOS-1:0] w_edge_clr;
  logic [NR_GPIOS-1:0] w_target;
  logic [NR_GPIOS-1:0] w_data;
  logic [NR_GPIOS-1:0] w_oe_next;
  logic [NR_GPIOS-1:0] w_out_next;
  logic [OP_W-1:0]     w_op;
  logic                w_dr_update;

  function automatic logic [NR_GPIOS-1:0] apply_op(
    input logic [NR_GPIOS-1:0] cur,
    input logic [NR_GPIOS-1:0] data,
    input logic [OP_W-1:0]     op
  );
    case (op)
      OP_WRITE: apply_op = data;
      OP_SET:   apply_op = cur | data;
      OP_CLR:   apply_op = cur & ~data;
      default:  apply_op = cur;
    endcase
  endfunction

  assign w_op        = r_dr[NR_GPIOS+1:NR_GPIOS];
  assign w_data      = r_dr[NR_GPIOS-1:0];
  // capture and shift outrank update when the TAP decodes overlap
  assign w_dr_update = extest_ir & ~capture_dr & ~shift_dr & update_dr;

  always_comb begin
    w_target   = r_oe;
    w_oe_next  = r_oe;
    w_out_next = r_out;
    w_edge_clr = '0;
    case (r_sel)
      SEL_OE:   w_target = r_oe;
      SEL_OUT:  w_target = r_out;
      SEL_IN:   w_target = w_in_sync;
      SEL_EDGE: w_target = w_edge_flags;
      default:  w_target = r_oe;
    endcase
    if (w_dr_update && r_sel == SEL_OE) begin
      w_oe_next = apply_op(r_oe, w_data, w_op);
    end else begin
      w_oe_next = r_oe;
    end
    if (w_dr_update && r_sel == SEL_OUT) begin
      w_out_next = apply_op(r_out, w_data, w_op);
    end else begin
      w_out_next = r_out;
    end
    // edge flags are write-1-to-clear only
    if (w_dr_update && r_sel == SEL_EDGE && w_op == OP_CLR) begin
      w_edge_clr = w_data;
    end else begin
      w_edge_clr = '0;
    end
  end

  always_ff @(posedge tck) begin
    if (!reset_) begin
      r_sel    <= SEL_OUT;
      r_sel_sr <= '0;
      r_dr     <= '0;
      r_oe     <= '0;
      r_out    <= '0;
    end else begin
      if (scan_n_ir) begin
        if (capture_dr) begin
          r_sel_sr <= r_sel;
        end else if (shift_dr) begin
          r_sel_sr <= {tdi, r_sel_sr[1]};
        end else if (update_dr) begin
          r_sel <= r_sel_sr;
        end
      end
      if (extest_ir) begin
        if (capture_dr) begin
          r_dr <= {2'b00, w_target};
        end else if (shift_dr) begin
          r_dr <= {tdi, r_dr[NR_GPIOS+1:1]};
        end
      end
      r_oe  <= w_oe_next;
      r_out <= w_out_next;
    end
  end

  jtag_gpio_edge_detect #(
    .NR_GPIOS    (NR_GPIOS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .tck         (tck),
    .reset_      (reset_),
    .gpio_inputs (gpio_inputs),
    .clr_mask    (w_edge_clr),
    .in_sync     (w_in_sync),
    .edge_flags  (w_edge_flags)
  );

  assign gpios_tdo         = scan_n_ir ? r_sel_sr[0] : r_dr[0];
  assign gpio_outputs      = r_out;
  assign gpio_outputs_ena  = r_oe;
  assign gpio_edge_pending = |w_edge_flags;

endmodule

// File: tb/tb_jtag_gpios_ext.sv
// Directed bench for jtag_gpios_ext: inputs change on the falling edge of tck
// and outputs are sampled on the falling edge after the acting rising edge.
module tb_jtag_gpios_ext;

  logic       tck = 1'b0;
  logic       reset_ = 1'b0;
  logic       tdi = 1'b0;
  logic       gpios_tdo;
  logic       capture_dr = 1'b0;
  logic       shift_dr = 1'b0;
  logic       update_dr = 1'b0;
  logic       scan_n_ir = 1'b0;
  logic       extest_ir = 1'b0;
  logic [7:0] gpio_inputs = 8'h00;
  logic [7:0] gpio_outputs;
  logic [7:0] gpio_outputs_ena;
  logic       gpio_edge_pending;

  int passed = 0;
  int total  = 0;

  always #5 tck = ~tck;

  jtag_gpios_ext #(.NR_GPIOS(8), .SYNC_STAGES(2)) dut (
    .tck               (tck),
    .reset_            (reset_),
    .tdi               (tdi),
    .gpios_tdo         (gpios_tdo),
    .capture_dr        (capture_dr),
    .shift_dr          (shift_dr),
    .update_dr         (update_dr),
    .scan_n_ir         (scan_n_ir),
    .extest_ir         (extest_ir),
    .gpio_inputs       (gpio_inputs),
    .gpio_outputs      (gpio_outputs),
    .gpio_outputs_ena  (gpio_outputs_ena),
    .gpio_edge_pending (gpio_edge_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // SCAN_N: capture, shift two bits, update; returns the captured selection
  task automatic sel_scan(input logic [1:0] v, output logic [1:0] got);
    scan_n_ir = 1'b1;
    @(negedge tck); capture_dr = 1'b1;
    @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b1; got[0] = gpios_tdo; tdi = v[0];
    @(negedge tck); got[1] = gpios_tdo; tdi = v[1];
    @(negedge tck); shift_dr = 1'b0; update_dr = 1'b1;
    @(negedge tck); update_dr = 1'b0; scan_n_ir = 1'b0;
  endtask

  // EXTEST: capture, shift 10 bits, update; toggle_at flips input bit 2 at that shift index
  task automatic dr_scan(input logic [9:0] v, input int toggle_at, output logic [7:0] got);
    extest_ir = 1'b1;
    @(negedge tck); capture_dr = 1'b1;
    @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge tck);
      if (i < 8) got[i] = gpios_tdo;
      tdi = v[i];
      if (i == toggle_at) gpio_inputs[2] = ~gpio_inputs[2];
    end
    @(negedge tck); shift_dr = 1'b0; update_dr = 1'b1;
    @(negedge tck); update_dr = 1'b0; extest_ir = 1'b0;
  endtask

  initial begin
    logic [1:0] s;
    logic [7:0] g;

    // 1. reset
    @(negedge tck); @(negedge tck);
    reset_ = 1'b1;
    check("rst_out", {24'd0, gpio_outputs}, 32'h00);
    check("rst_oe", {24'd0, gpio_outputs_ena}, 32'h00);
    check("rst_pending", {31'd0, gpio_edge_pending}, 32'h0);
    sel_scan(2'b01, s);
    check("rst_sel", {30'd0, s}, 32'h1);

    // 2. select OE and write
    sel_scan(2'b00, s);
    dr_scan({2'b01, 8'hA5}, -1, g);
    check("oe_write", {24'd0, gpio_outputs_ena}, 32'hA5);
    check("out_untouched", {24'd0, gpio_outputs}, 32'h00);

    // 3. set / clear / read-only on OUT
    sel_scan(2'b01, s);
    dr_scan({2'b01, 8'h0F}, -1, g);
    dr_scan({2'b10, 8'h30}, -1, g);
    check("out_set", {24'd0, gpio_outputs}, 32'h3F);
    dr_scan({2'b11, 8'h05}, -1, g);
    check("out_clr", {24'd0, gpio_outputs}, 32'h3A);
    dr_scan({2'b00, 8'hFF}, -1, g);
    check("out_readback", {24'd0, g}, 32'h3A);
    check("out_nop", {24'd0, gpio_outputs}, 32'h3A);

    // 4. input snapshot, writes ignored
    gpio_inputs = 8'hC3;
    repeat (3) @(negedge tck);
    sel_scan(2'b10, s);
    dr_scan({2'b01, 8'h00}, -1, g);
    check("in_capture", {24'd0, g}, 32'hC3);
    check("in_oe_hold", {24'd0, gpio_outputs_ena}, 32'hA5);
    check("in_out_hold", {24'd0, gpio_outputs}, 32'h3A);
    dr_scan({2'b00, 8'h00}, -1, g);
    check("in_recapture", {24'd0, g}, 32'hC3);

    // 5. edge flags
    sel_scan(2'b11, s);
    dr_scan({2'b10, 8'hFF}, -1, g);
    check("edge_set_ignored", {24'd0, g}, 32'hC3);
    dr_scan({2'b11, 8'hFF}, -1, g);
    check("edge_clear_all", {31'd0, gpio_edge_pending}, 32'h0);
    gpio_inputs[2] = 1'b1;
    repeat (2) @(negedge tck);
    check("edge_not_yet", {31'd0, gpio_edge_pending}, 32'h0);
    @(negedge tck);
    check("edge_pending", {31'd0, gpio_edge_pending}, 32'h1);
    dr_scan({2'b00, 8'h00}, -1, g);
    check("edge_flags", {24'd0, g}, 32'h04);
    dr_scan({2'b11, 8'h04}, 8, g);
    check("edge_set_wins", {31'd0, gpio_edge_pending}, 32'h1);
    dr_scan({2'b00, 8'h00}, -1, g);
    check("edge_flags_kept", {24'd0, g}, 32'h04);
    dr_scan({2'b11, 8'h04}, -1, g);
    check("edge_cleared", {31'd0, gpio_edge_pending}, 32'h0);
    dr_scan({2'b00, 8'h00}, -1, g);
    check("edge_flags_zero", {24'd0, g}, 32'h00);

    // 6. reset in the middle of an OE write scan
    sel_scan(2'b00, s);
    extest_ir = 1'b1;
    @(negedge tck); capture_dr = 1'b1;
    @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge tck);
      tdi = (i < 2) ? 1'b1 : 1'b1;
    end
    @(negedge tck); reset_ = 1'b0;
    @(negedge tck); reset_ = 1'b1; shift_dr = 1'b0; update_dr = 1'b1;
    check("midrst_pending", {31'd0, gpio_edge_pending}, 32'h0);
    @(negedge tck); update_dr = 1'b0; extest_ir = 1'b0;
    check("midrst_oe", {24'd0, gpio_outputs_ena}, 32'h00);
    check("midrst_out", {24'd0, gpio_outputs}, 32'h00);
    sel_scan(2'b01, s);
    check("midrst_sel", {30'd0, s}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
